// File: rtl/seq_detect_param_if.sv
// Purpose : bundles the serial-data, pattern-load and status signals of the
//           parametrised sequence detector.
// Modports:
//   master - bit source / controller: drives x, x_valid, mode_ovl, pat_load,
//            pat_in, len_in, cnt_clr; observes y, match_cnt
//   slave  - detector: receives the controls, drives y and match_cnt
interface seq_detect_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               x;
    logic               x_valid;
    logic               mode_ovl;
    logic               pat_load;
    logic [MAX_LEN-1:0] pat_in;
    logic [LW-1:0]      len_in;
    logic               cnt_clr;
    logic               y;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output x, x_valid, mode_ovl, pat_load, pat_in, len_in, cnt_clr,
        input  y, match_cnt
    );

    modport slave (
        input  x, x_valid, mode_ovl, pat_load, pat_in, len_in, cnt_clr,
        output y, match_cnt
    );
endinterface

// File: rtl/seq_detect_param.sv
// Purpose : serial pattern detector with run-time loadable pattern/length,
//           overlapping or non-overlapping matching, input-valid qualification
//           and a saturating match counter.
// Ports   :
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - seq_detect_param_if.slave: x/x_valid serial input, mode_ovl,
//          pat_load/pat_in/len_in pattern loading, cnt_clr, registered
//          outputs y (one-cycle match pulse) and match_cnt.
// The most recently accepted bit is compared against pattern bit 0, so
// pattern bit [len-1] is the first bit of the sequence on the wire.
module seq_detect_param #(
    parameter int                 MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0001_0101,
    parameter int                 DEF_LEN     = 5,
    parameter int                 CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_param_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);

    // Mask with the low l bits set.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LW-1:0] l);
        logic [MAX_LEN-1:0] m;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (i < int'(l));
        end
        return m;
    endfunction

    // Length clamped into 1..MAX_LEN.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        logic [LW-1:0] c;
        if (l == LW'(0)) begin
            c = LW'(1);
        end else if (l > LW'(MAX_LEN)) begin
            c = LW'(MAX_LEN);
        end else begin
            c = l;
        end
        return c;
    endfunction

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q,  pat_d;
    logic [LW-1:0]      len_q,  len_d;
    logic               y_q,    y_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;

    logic [MAX_LEN-1:0] shifted_s;
    logic [MAX_LEN-1:0] mask_s;
    logic [LW:0]        fill_inc_s;
    logic [LW-1:0]      len_new_s;
    logic               accept_s;
    logic               match_s;

    // Next-state: shift/match on accepted bits, pattern load, counter update.
    always_comb begin
        hist_d     = hist_q;
        fill_d     = fill_q;
        pat_d      = pat_q;
        len_d      = len_q;
        cnt_d      = cnt_q;

        // Loading the pattern takes precedence over (and drops) a valid bit.
        accept_s   = bus.x_valid & ~bus.pat_load;
        shifted_s  = {hist_q[MAX_LEN-2:0], bus.x};
        mask_s     = len_mask(len_q);
        fill_inc_s = {1'b0, fill_q} + (LW + 1)'(1);
        len_new_s  = clamp_len(bus.len_in);
        // fill+1 >= len guarantees the masked window holds only fresh bits.
        match_s    = accept_s && (fill_inc_s >= {1'b0, len_q}) &&
                     ((shifted_s & mask_s) == (pat_q & mask_s));
        y_d        = match_s;

        if (bus.pat_load) begin
            pat_d  = bus.pat_in & len_mask(len_new_s);
            len_d  = len_new_s;
            hist_d = {MAX_LEN{1'b0}};
            fill_d = LW'(0);
        end else if (accept_s) begin
            hist_d = shifted_s;
            if (match_s && !bus.mode_ovl) begin
                fill_d = LW'(0);
            end else if (fill_q < LW'(MAX_LEN)) begin
                fill_d = fill_q + LW'(1);
            end else begin
                fill_d = fill_q;
            end
        end else begin
            hist_d = hist_q;
        end

        // Clear wins over a same-cycle increment; the count never wraps.
        if (bus.cnt_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (match_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset to the default pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= {MAX_LEN{1'b0}};
            fill_q <= LW'(0);
            pat_q  <= DEF_PATTERN;
            len_q  <= LW'(DEF_LEN);
            y_q    <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.y         = y_q;
    assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;
    localparam int MAX_LEN = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_detect_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(8)) bus8 ();
    seq_detect_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(2)) bus2 ();

    seq_detect_param #(.MAX_LEN(MAX_LEN), .DEF_PATTERN(8'b0001_0101), .DEF_LEN(5), .CNT_W(8))
        dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    seq_detect_param #(.MAX_LEN(MAX_LEN), .DEF_PATTERN(8'b0001_0101), .DEF_LEN(5), .CNT_W(2))
        dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    int vectors    = 0;
    int miscompares = 0;
    int pulses     = 0;
    logic cur_ovl  = 1'b1;

    // Reference model: the accepted bits since the last reset/load/non-overlap
    // match, newest at the back; pattern bit 0 must equal the newest bit.
    bit       mq[$];
    bit [7:0] m_pat;
    int       m_len;
    bit       m_y;
    int       m_cnt8;
    int       m_cnt2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_match();
        if (mq.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (mq[mq.size() - 1 - i] != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step(input logic r, input logic xb, input logic xv, input logic ovl,
                        input logic ld, input logic [7:0] pin, input logic [3:0] lin,
                        input logic cl);
        int l;
        rst = r;
        bus8.x = xb; bus8.x_valid = xv; bus8.mode_ovl = ovl; bus8.pat_load = ld;
        bus8.pat_in = pin; bus8.len_in = lin; bus8.cnt_clr = cl;
        bus2.x = xb; bus2.x_valid = xv; bus2.mode_ovl = ovl; bus2.pat_load = ld;
        bus2.pat_in = pin; bus2.len_in = lin; bus2.cnt_clr = cl;
        if (r) begin
            mq.delete(); m_pat = 8'b0001_0101; m_len = 5; m_y = 1'b0;
            m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            m_y = 1'b0;
            if (ld) begin
                l = int'(lin);
                if (l == 0) l = 1;
                if (l > MAX_LEN) l = MAX_LEN;
                m_len = l;
                m_pat = 8'h00;
                for (int i = 0; i < l; i++) m_pat[i] = pin[i];
                mq.delete();
            end else if (xv) begin
                mq.push_back(xb);
                if (mq.size() > MAX_LEN) void'(mq.pop_front());
                m_y = model_match();
                if (m_y && !ovl) mq.delete();
            end
            if (cl) begin
                m_cnt8 = 0; m_cnt2 = 0;
            end else if (m_y) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        @(posedge clk);
        #1;
        if (bus8.y) pulses++;
        chk("y", 32'(bus8.y), 32'(m_y));
        chk("cnt8", 32'(bus8.match_cnt), 32'(m_cnt8));
        chk("y_w2", 32'(bus2.y), 32'(m_y));
        chk("cnt2", 32'(bus2.match_cnt), 32'(m_cnt2));
    endtask

    task automatic sbit(input logic b);
        step(1'b0, b, 1'b1, cur_ovl, 1'b0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic bubble();
        step(1'b0, 1'b0, 1'b0, cur_ovl, 1'b0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic clr();
        step(1'b0, 1'b0, 1'b0, cur_ovl, 1'b0, 8'h00, 4'd0, 1'b1);
    endtask

    task automatic do_rst();
        step(1'b1, 1'b0, 1'b0, cur_ovl, 1'b0, 8'h00, 4'd0, 1'b0);
    endtask

    initial begin
        logic [8:0] alt9;
        alt9 = 9'b1_0101_0101;

        // Reset state
        do_rst();
        do_rst();
        chk("rst_y", 32'(bus8.y), 32'd0);
        chk("rst_cnt", 32'(bus8.match_cnt), 32'd0);

        // Overlapping: 101010101 -> matches after bits 5, 7, 9
        cur_ovl = 1'b1; pulses = 0;
        for (int i = 8; i >= 0; i--) sbit(alt9[i]);
        chk("ovl_pulses", 32'(pulses), 32'd3);
        chk("ovl_cnt", 32'(bus8.match_cnt), 32'd3);

        // Non-overlapping: same stream -> one match
        clr();
        cur_ovl = 1'b0; pulses = 0;
        for (int i = 8; i >= 0; i--) sbit(alt9[i]);
        chk("novl_pulses", 32'(pulses), 32'd1);
        chk("novl_cnt", 32'(bus8.match_cnt), 32'd1);

        // Bubbles between bits keep progress
        do_rst();
        cur_ovl = 1'b1; pulses = 0;
        for (int i = 4; i >= 0; i--) begin
            sbit(alt9[i]);
            if (i != 0) begin
                for (int g = 0; g < 1 + (i % 3); g++) bubble();
            end
        end
        chk("gap_pulses", 32'(pulses), 32'd1);

        // Load 3'b110 len 3: 110110 -> matches after bits 3 and 6
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b1111_1110, 4'd3, 1'b0);
        pulses = 0;
        sbit(1'b1); sbit(1'b1); sbit(1'b0);
        chk("l3_first", 32'(bus8.y), 32'd1);
        sbit(1'b1); sbit(1'b1); sbit(1'b0);
        chk("l3_pulses", 32'(pulses), 32'd2);

        // len_in=0 clamps to 1, pattern "1"
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b0000_0011, 4'd0, 1'b0);
        pulses = 0;
        sbit(1'b1); sbit(1'b0); sbit(1'b1);
        chk("l1_pulses", 32'(pulses), 32'd2);

        // len_in above MAX_LEN clamps to MAX_LEN
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b1100_1010, 4'd12, 1'b0);
        pulses = 0;
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] p;
            p = 8'b1100_1010;
            sbit(p[i]);
        end
        chk("l8_pulses", 32'(pulses), 32'd1);

        // Saturation: 11 alternating bits -> 4 matches, 2-bit counter stuck at 3
        do_rst();
        cur_ovl = 1'b1;
        for (int i = 0; i < 11; i++) sbit(((i % 2) == 0) ? 1'b1 : 1'b0);
        chk("sat_cnt8", 32'(bus8.match_cnt), 32'd4);
        chk("sat_cnt2", 32'(bus2.match_cnt), 32'd3);
        sbit(1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
        chk("clr_y", 32'(bus8.y), 32'd1);
        chk("clr_cnt", 32'(bus8.match_cnt), 32'd0);

        // Reset mid-sequence discards progress and restores 10101
        sbit(1'b1); sbit(1'b0); sbit(1'b1); sbit(1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        pulses = 0;
        sbit(1'b1);
        chk("postrst_y", 32'(bus8.y), 32'd0);
        sbit(1'b0); sbit(1'b1); sbit(1'b0); sbit(1'b1);
        chk("postrst_pulses", 32'(pulses), 32'd1);

        // pat_load with a valid bit: the bit is dropped
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'b0001_0101, 4'd5, 1'b0);
        pulses = 0;
        sbit(1'b0); sbit(1'b1); sbit(1'b0); sbit(1'b1);
        chk("drop_pulses", 32'(pulses), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic r, ld, cl;
            r  = ($urandom_range(0, 79) == 0);
            ld = ($urandom_range(0, 39) == 0);
            cl = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) cur_ovl = ~cur_ovl;
            step(r, 1'($urandom), ($urandom_range(0, 3) != 0), cur_ovl, ld,
                 8'($urandom), 4'($urandom_range(0, 15)), cl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
